branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/bp_pkg.sv | 32 +++
 rtl/branch_resolve_if.sv | 53 +++++
 rtl/bp_track_reg.sv | 49 ++++
 rtl/branch_resolve.sv | 127 ++++++++++++
 tb/tb_branch_resolve.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared branch-prediction definitions. The branch resolve block and the
// predictor both use them.
//   PC_W          : default PC width in bits
//   CNT_W         : default width of each statistics counter
//   trk_ctl_e     : per-cycle action for one pipeline tracking register
//   track_entry_t : field layout of one tracking entry {valid, pc, bp_taken,
//                   bp_target}, as the predictor sees it
// -----------------------------------------------------------------------------
package bp_pkg;

    localparam int PC_W  = 5;
    localparam int CNT_W = 8;

    // LOAD : take the upstream entry
    // HOLD : keep the current entry (stalled stage)
    // KILL : clear valid and keep the other fields (bubble or flush)
    typedef enum logic [1:0] {
        TRK_LOAD = 2'd0,
        TRK_HOLD = 2'd1,
        TRK_KILL = 2'd2
    } trk_ctl_e;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        logic            bp_taken;
        logic [PC_W-1:0] bp_target;
    } track_entry_t;

endpackage

// File: rtl/branch_resolve_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_if
// Bundles the fetch-side, stall, execute-side, redirect, predictor-update and
// statistics signals of the branch resolve block.
//   master : pipeline side. It drives F_*, stall and EX_* and observes the
//            results.
//   slave  : branch_resolve. It consumes F_*, stall and EX_*, and produces
//            EX_pc, mispredict, redirect_pc, flush, upd_* and the counters.
// -----------------------------------------------------------------------------
interface branch_resolve_if #(
    parameter int PC_W  = bp_pkg::PC_W,
    parameter int CNT_W = bp_pkg::CNT_W
);
    // Fetch stage
    logic             F_valid;
    logic [PC_W-1:0]  F_pc;
    logic             F_BP_taken;
    logic [PC_W-1:0]  F_BP_target_pc;
    // Hazard stall
    logic             stall;
    // Execute stage resolution
    logic             EX_brn;
    logic             EX_true_taken;
    logic [PC_W-1:0]  EX_alu_out;
    // Results
    logic [PC_W-1:0]  EX_pc;
    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;
    logic             flush;
    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic [PC_W-1:0]  upd_target;
    logic             upd_taken;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;

    modport master (
        output F_valid, F_pc, F_BP_taken, F_BP_target_pc, stall,
               EX_brn, EX_true_taken, EX_alu_out,
        input  EX_pc, mispredict, redirect_pc, flush,
               upd_valid, upd_pc, upd_target, upd_taken,
               br_count, mp_count
    );

    modport slave (
        input  F_valid, F_pc, F_BP_taken, F_BP_target_pc, stall,
               EX_brn, EX_true_taken, EX_alu_out,
        output EX_pc, mispredict, redirect_pc, flush,
               upd_valid, upd_pc, upd_target, upd_taken,
               br_count, mp_count
    );

endinterface

// File: rtl/bp_track_reg.sv
// -----------------------------------------------------------------------------
// bp_track_reg
// One pipeline tracking register holding {valid, pc, bp_taken, bp_target}.
// The top module instantiates it twice, once for D and once for E.
//   clk, rst          : clock and synchronous active-high reset (clears all)
//   ctl               : LOAD / HOLD / KILL for this edge
//   in_*              : upstream entry, taken on LOAD
//   q_*               : current entry
// -----------------------------------------------------------------------------
module bp_track_reg #(
    parameter int PC_W = bp_pkg::PC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  bp_pkg::trk_ctl_e  ctl,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_bp_taken,
    input  logic [PC_W-1:0]   in_bp_target,
    output logic              q_valid,
    output logic [PC_W-1:0]   q_pc,
    output logic              q_bp_taken,
    output logic [PC_W-1:0]   q_bp_target
);
    import bp_pkg::*;

    // NOTE: state registers use non-blocking assignments so that every
    // register samples its pre-edge inputs, whatever the order of the blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid     <= 1'b0;
            q_pc        <= '0;
            q_bp_taken  <= 1'b0;
            q_bp_target <= '0;
        end else begin
            case (ctl)
                TRK_LOAD: begin
                    q_valid     <= in_valid;
                    q_pc        <= in_pc;
                    q_bp_taken  <= in_bp_taken;
                    q_bp_target <= in_bp_target;
                end
                TRK_KILL: q_valid <= 1'b0;
                default:  ;  // TRK_HOLD keeps the current entry
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
// Tracks the prediction made for each fetched instruction through D and E.
// When the instruction reaches EX, the block compares that prediction with
// the resolved outcome. On a wrong prediction it redirects fetch and flushes
// the younger stages. It also updates the predictor and counts resolved
// branches and mispredictions.
//   clk, rst : clock and synchronous active-high reset
//   bus      : branch_resolve_if.slave
//              inputs  F_valid/F_pc/F_BP_taken/F_BP_target_pc, stall,
//                      EX_brn/EX_true_taken/EX_alu_out
//              outputs EX_pc, mispredict, redirect_pc, flush,
//                      upd_valid/upd_pc/upd_target/upd_taken,
//                      br_count, mp_count (saturating)
// -----------------------------------------------------------------------------
module branch_resolve #(
    parameter int PC_W  = bp_pkg::PC_W,
    parameter int CNT_W = bp_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    branch_resolve_if.slave bus
);
    import bp_pkg::*;

    logic            d_valid, e_valid;
    logic [PC_W-1:0] d_pc, e_pc;
    logic            d_bp_taken, e_bp_taken;
    logic [PC_W-1:0] d_bp_target, e_bp_target;

    trk_ctl_e        d_ctl, e_ctl;

    logic            br_wrong;
    logic            stale_entry;
    logic            mp;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] redirect_pc;
    logic [CNT_W-1:0] br_count, mp_count;

    // ---------------------------------------------------------------- tracking
    // Flush wins over stall. A stall holds D and injects a bubble into E.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        d_ctl = TRK_LOAD;
        e_ctl = TRK_LOAD;
        if (mp) begin
            d_ctl = TRK_KILL;
            e_ctl = TRK_KILL;
        end else if (bus.stall) begin
            d_ctl = TRK_HOLD;
            e_ctl = TRK_KILL;
        end
    end

    bp_track_reg #(.PC_W(PC_W)) u_d_reg (
        .clk          (clk),
        .rst          (rst),
        .ctl          (d_ctl),
        .in_valid     (bus.F_valid),
        .in_pc        (bus.F_pc),
        .in_bp_taken  (bus.F_BP_taken),
        .in_bp_target (bus.F_BP_target_pc),
        .q_valid      (d_valid),
        .q_pc         (d_pc),
        .q_bp_taken   (d_bp_taken),
        .q_bp_target  (d_bp_target)
    );

    bp_track_reg #(.PC_W(PC_W)) u_e_reg (
        .clk          (clk),
        .rst          (rst),
        .ctl          (e_ctl),
        .in_valid     (d_valid),
        .in_pc        (d_pc),
        .in_bp_taken  (d_bp_taken),
        .in_bp_target (d_bp_target),
        .q_valid      (e_valid),
        .q_pc         (e_pc),
        .q_bp_taken   (e_bp_taken),
        .q_bp_target  (e_bp_target)
    );

    // ----------------------------------------------------------------- compare
    // A real branch is wrong if the direction is wrong, or if it was taken to
    // a different target. A non-branch that was predicted taken is a stale
    // predictor entry, and fetch already went down the wrong path.
    assign br_wrong    = e_valid & bus.EX_brn &
                         ((e_bp_taken != bus.EX_true_taken) |
                          (bus.EX_true_taken & (e_bp_target != bus.EX_alu_out)));
    assign stale_entry = e_valid & ~bus.EX_brn & e_bp_taken;
    assign mp          = br_wrong | stale_entry;

    // The sequential successor wraps at PC_W bits.
    assign seq_pc = e_pc + PC_W'(1);

    always_comb begin
        redirect_pc = '0;
        if (mp) begin
            redirect_pc = (bus.EX_brn & bus.EX_true_taken) ? bus.EX_alu_out : seq_pc;
        end
    end

    // ---------------------------------------------------------------- counters
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count <= '0;
            mp_count <= '0;
        end else begin
            if (bus.upd_valid && (br_count != '1)) br_count <= br_count + CNT_W'(1);
            if (mp && (mp_count != '1))            mp_count <= mp_count + CNT_W'(1);
        end
    end

    // ----------------------------------------------------------------- outputs
    assign bus.EX_pc       = e_pc;
    assign bus.mispredict  = mp;
    assign bus.flush       = mp;
    assign bus.redirect_pc = redirect_pc;
    assign bus.upd_valid   = e_valid & bus.EX_brn;
    assign bus.upd_pc      = e_pc;
    assign bus.upd_target  = bus.EX_alu_out;
    assign bus.upd_taken   = bus.EX_true_taken;
    assign bus.br_count    = br_count;
    assign bus.mp_count    = mp_count;

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
// Self-checking bench for branch_resolve. A behavioural model of the two
// tracked slots and the counters runs beside the DUT. A compare process
// checks every output on each falling edge. Directed sequences pin the model
// with literal expectations, and a randomized phase exercises the rest.
// -----------------------------------------------------------------------------
module tb_branch_resolve;

    localparam int PW      = 5;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    branch_resolve_if #(.PC_W(PW), .CNT_W(CW)) bus ();

    branch_resolve #(.PC_W(PW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ------------------------------------------------------------------ model
    typedef struct {
        bit          v;
        bit [PW-1:0] pc;
        bit          bt;
        bit [PW-1:0] tg;
    } ent_t;

    ent_t md, me;
    int   mbr = 0;
    int   mmp = 0;

    function automatic bit m_mispredict();
        if (!me.v) return 1'b0;
        if (bus.EX_brn)
            return (me.bt != bus.EX_true_taken) ||
                   (bus.EX_true_taken && (me.tg != bus.EX_alu_out));
        return me.bt;
    endfunction

    function automatic int m_redirect();
        if (!m_mispredict()) return 0;
        if (bus.EX_brn && bus.EX_true_taken) return int'(bus.EX_alu_out);
        return (int'(me.pc) + 1) % (1 << PW);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            md  <= '{default: 0};
            me  <= '{default: 0};
            mbr <= 0;
            mmp <= 0;
        end else begin
            if (me.v && bus.EX_brn) mbr <= (mbr < CNT_MAX) ? mbr + 1 : mbr;
            if (m_mispredict())     mmp <= (mmp < CNT_MAX) ? mmp + 1 : mmp;
            if (m_mispredict()) begin
                md.v <= 1'b0;
                me.v <= 1'b0;
            end else if (bus.stall) begin
                me.v <= 1'b0;
            end else begin
                md <= '{bus.F_valid, bus.F_pc, bus.F_BP_taken, bus.F_BP_target_pc};
                me <= md;
            end
        end
    end

    // ---------------------------------------------------------------- checker
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("mispredict",  32'(bus.mispredict),  32'(m_mispredict()));
            check("flush",       32'(bus.flush),       32'(m_mispredict()));
            check("redirect_pc", 32'(bus.redirect_pc), 32'(m_redirect()));
            check("upd_valid",   32'(bus.upd_valid),   32'(me.v && bus.EX_brn));
            if (me.v) begin
                check("EX_pc",  32'(bus.EX_pc),  32'(me.pc));
                check("upd_pc", 32'(bus.upd_pc), 32'(me.pc));
            end
            check("upd_target", 32'(bus.upd_target), 32'(bus.EX_alu_out));
            check("upd_taken",  32'(bus.upd_taken),  32'(bus.EX_true_taken));
            check("br_count",   32'(bus.br_count),   32'(mbr));
            check("mp_count",   32'(bus.mp_count),   32'(mmp));
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic set_f(input bit v, input int pc, input bit bt, input int tg);
        bus.F_valid        = v;
        bus.F_pc           = PW'(pc);
        bus.F_BP_taken     = bt;
        bus.F_BP_target_pc = PW'(tg);
    endtask

    task automatic set_ex(input bit brn, input bit tt, input int alu);
        bus.EX_brn        = brn;
        bus.EX_true_taken = tt;
        bus.EX_alu_out    = PW'(alu);
    endtask

    task automatic idle();
        set_f(1'b0, 0, 1'b0, 0);
        set_ex(1'b0, 1'b0, 0);
        bus.stall = 1'b0;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state: E is empty, so an EX branch must not update anything.
        set_ex(1'b1, 1'b1, 7);
        to_neg();
        check("rst_mispredict", 32'(bus.mispredict),  0);
        check("rst_flush",      32'(bus.flush),       0);
        check("rst_upd_valid",  32'(bus.upd_valid),   0);
        check("rst_redirect",   32'(bus.redirect_pc), 0);
        check("rst_EX_pc",      32'(bus.EX_pc),       0);
        check("rst_br_count",   32'(bus.br_count),    0);
        check("rst_mp_count",   32'(bus.mp_count),    0);
        to_next();

        // Correct not-taken prediction at pc 4.
        idle(); set_f(1'b1, 4, 1'b0, 0); to_neg(); to_next();
        idle(); to_neg(); to_next();
        idle(); set_ex(1'b1, 1'b0, 5); to_neg();
        check("nt_mispredict", 32'(bus.mispredict), 0);
        check("nt_upd_valid",  32'(bus.upd_valid),  1);
        check("nt_EX_pc",      32'(bus.EX_pc),      4);
        to_next();
        idle(); to_neg();
        check("nt_br_count", 32'(bus.br_count), 1);
        check("nt_mp_count", 32'(bus.mp_count), 0);
        to_next();

        // Wrong target: predicted 10, resolved 12; pc 7 behind it gets flushed.
        idle(); set_f(1'b1, 6, 1'b1, 10); to_neg(); to_next();
        idle(); set_f(1'b1, 7, 1'b0, 0);  to_neg(); to_next();
        idle(); set_f(1'b1, 8, 1'b0, 0); set_ex(1'b1, 1'b1, 12); to_neg();
        check("wt_mispredict", 32'(bus.mispredict),  1);
        check("wt_flush",      32'(bus.flush),       1);
        check("wt_redirect",   32'(bus.redirect_pc), 12);
        to_next();
        idle(); set_ex(1'b1, 1'b1, 12); to_neg();
        check("wt_e_invalid", 32'(bus.upd_valid), 0);
        to_next();
        idle(); set_ex(1'b1, 1'b1, 12); to_neg();
        check("wt_d_invalid", 32'(bus.upd_valid), 0);
        check("wt_br_count",  32'(bus.br_count),  2);
        check("wt_mp_count",  32'(bus.mp_count),  1);
        to_next();

        // Stale entry at pc 31: the sequential redirect wraps to 0.
        idle(); set_f(1'b1, 31, 1'b1, 3); to_neg(); to_next();
        idle(); to_neg(); to_next();
        idle(); to_neg();
        check("st_mispredict", 32'(bus.mispredict),  1);
        check("st_redirect",   32'(bus.redirect_pc), 0);
        check("st_upd_valid",  32'(bus.upd_valid),   0);
        to_next();
        idle(); to_neg();
        check("st_mp_count", 32'(bus.mp_count), 2);
        check("st_br_count", 32'(bus.br_count), 2);
        to_next();

        // Two stall cycles with branch pc 3 sitting in D.
        idle(); set_f(1'b1, 3, 1'b0, 0); to_neg(); to_next();
        idle(); bus.stall = 1'b1; to_neg(); to_next();
        idle(); bus.stall = 1'b1; set_ex(1'b1, 1'b0, 4); to_neg();
        check("stall_bubble1", 32'(bus.upd_valid), 0);
        to_next();
        idle(); set_ex(1'b1, 1'b0, 4); to_neg();
        check("stall_bubble2", 32'(bus.upd_valid), 0);
        to_next();
        idle(); set_ex(1'b1, 1'b0, 4); to_neg();
        check("stall_EX_pc",      32'(bus.EX_pc),      3);
        check("stall_upd_valid",  32'(bus.upd_valid),  1);
        check("stall_mispredict", 32'(bus.mispredict), 0);
        to_next();
        idle(); set_ex(1'b1, 1'b0, 4); to_neg();
        check("stall_once", 32'(bus.upd_valid), 0);
        check("stall_br_count", 32'(bus.br_count), 3);
        to_next();

        // Stall and mispredict together: flush must win over D's hold.
        idle(); set_f(1'b1, 10, 1'b0, 0); to_neg(); to_next();
        idle(); set_f(1'b1, 11, 1'b0, 0); to_neg(); to_next();
        idle(); bus.stall = 1'b1; set_f(1'b1, 12, 1'b0, 0); set_ex(1'b1, 1'b1, 9); to_neg();
        check("sf_mispredict", 32'(bus.mispredict),  1);
        check("sf_redirect",   32'(bus.redirect_pc), 9);
        to_next();
        idle(); set_ex(1'b1, 1'b0, 0); to_neg();
        check("sf_e_invalid", 32'(bus.upd_valid), 0);
        to_next();
        idle(); set_ex(1'b1, 1'b0, 0); to_neg();
        check("sf_d_invalid", 32'(bus.upd_valid), 0);
        check("sf_br_count",  32'(bus.br_count),  4);
        check("sf_mp_count",  32'(bus.mp_count),  3);
        to_next();

        // Randomized traffic checked by the model, with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            rst                = ($urandom_range(0, 99) == 0);
            bus.F_valid        = ($urandom_range(0, 9) < 7);
            bus.F_pc           = PW'($urandom);
            bus.F_BP_taken     = ($urandom_range(0, 9) < 4);
            bus.F_BP_target_pc = PW'($urandom);
            bus.stall          = ($urandom_range(0, 4) == 0);
            bus.EX_brn         = 1'($urandom_range(0, 1));
            bus.EX_true_taken  = 1'($urandom_range(0, 1));
            bus.EX_alu_out     = ($urandom_range(0, 1) == 1) ? me.tg : PW'($urandom);
            to_next();
        end

        // Saturation: a steady stream of mispredicting branches.
        idle(); rst = 1'b1; to_next();
        rst = 1'b0;
        set_f(1'b1, 0, 1'b1, 0);
        set_ex(1'b1, 1'b0, 0);
        for (int i = 0; i < 960; i++) to_next();
        to_neg();
        check("sat_br_count", 32'(bus.br_count), 255);
        check("sat_mp_count", 32'(bus.mp_count), 255);
        to_next();

        // Reset in the middle of a flush discards it and clears the counters.
        for (int k = 0; k < 4 && !m_mispredict(); k++) to_next();
        check("sat_flush_pending", 32'(bus.flush), 1);
        rst = 1'b1;
        to_next();
        rst = 1'b0;
        idle(); set_ex(1'b1, 1'b1, 5); to_neg();
        check("rst2_br_count",   32'(bus.br_count),   0);
        check("rst2_mp_count",   32'(bus.mp_count),   0);
        check("rst2_mispredict", 32'(bus.mispredict), 0);
        check("rst2_upd_valid",  32'(bus.upd_valid),  0);
        check("rst2_EX_pc",      32'(bus.EX_pc),      0);
        to_next();
        idle(); set_ex(1'b1, 1'b1, 5); to_neg();
        check("rst2_d_invalid", 32'(bus.upd_valid), 0);
        to_next();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
